// File: rtl/bus_responder.sv
// Bus responder for the 6502 core: 2 KiB RAM, TX FIFO, status register and
// a free-running tick counter, all returning read data one cycle after the address.
module bus_responder #(
   parameter int RAM_AW     = 11,
   parameter     INIT_FILE  = "",
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RW,
   input  logic [15:0] AD,
   input  logic [7:0]  D_in,
   output logic [7:0]  D_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int RAM_SIZE = 1 << RAM_AW;
   localparam int PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW       = $clog2(FIFO_DEPTH + 1);

   localparam logic [15:0] A_TXDATA  = 16'h8000;
   localparam logic [15:0] A_STATUS  = 16'h8001;
   localparam logic [15:0] A_TICK_LO = 16'h8002;
   localparam logic [15:0] A_TICK_HI = 16'h8003;

   logic [7:0]    r_ram [RAM_SIZE];
   logic [7:0]    r_fifo [FIFO_DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic [15:0]   r_tick;
   logic [7:0]    r_tick_shadow;
   logic [7:0]    r_d_out;

   logic              w_ram_sel;
   logic [RAM_AW-1:0] w_ram_addr;
   logic              w_ram_wr;
   logic              w_tx_wr;
   logic              w_stat_wr;
   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic              w_push;
   logic              w_ovf_set;
   logic [4:0]        w_count5;
   logic [7:0]        w_status;
   logic [7:0]        w_rd_data;

   // RAM occupies only the bottom of the map; no mirroring above its size.
   assign w_ram_sel  = (AD[15:RAM_AW] == '0);
   assign w_ram_addr = AD[RAM_AW-1:0];

   assign w_ram_wr  = !RW && w_ram_sel;
   assign w_tx_wr   = !RW && (AD == A_TXDATA);
   assign w_stat_wr = !RW && (AD == A_STATUS);

   assign w_full    = (r_count == CW'(FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_pop     = !w_empty && tx_ready;
   // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
   assign w_push    = w_tx_wr && (!w_full || w_pop);
   assign w_ovf_set = w_tx_wr && w_full && !w_pop;

   assign w_count5 = 5'(r_count);
   assign w_status = {r_overflow, w_count5, w_empty, w_full};

   always_comb begin
      w_rd_data = 8'hFF;
      if (w_ram_sel) begin
         w_rd_data = r_ram[w_ram_addr];
      end else begin
         case (AD)
            A_TXDATA:  w_rd_data = 8'h00;
            A_STATUS:  w_rd_data = w_status;
            A_TICK_LO: w_rd_data = r_tick[7:0];
            A_TICK_HI: w_rd_data = r_tick_shadow;
            default:   w_rd_data = 8'hFF;
         endcase
      end
   end

   // Write-first: a read the cycle after a write sees the new byte.
   always_ff @(posedge clk) begin
      if (w_ram_wr) r_ram[w_ram_addr] <= D_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= 8'h00;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= D_in;
            r_wr_ptr         <= r_wr_ptr + PW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_stat_wr)      r_overflow <= 1'b0;
         else if (w_ovf_set) r_overflow <= 1'b1;
      end
   end

   // The shadow only moves on a TICK_LO read, making LO-then-HI atomic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick        <= 16'h0000;
         r_tick_shadow <= 8'h00;
         r_d_out       <= 8'h00;
      end else begin
         r_tick <= r_tick + 16'd1;
         if (RW && (AD == A_TICK_LO)) r_tick_shadow <= r_tick[15:8];
         if (RW) r_d_out <= w_rd_data;
      end
   end

   assign D_out    = r_d_out;
   assign tx_valid = !w_empty;
   assign tx_data  = r_fifo[r_rd_ptr];

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: RAM, TX FIFO, status, tick and mid-run reset.
module tb_bus_responder;

   logic        clk;
   logic        rst;
   logic        RW;
   logic [15:0] AD;
   logic [7:0]  D_in;
   logic [7:0]  D_out;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference tick: counts edges since the last reset.
   logic [15:0] m_tick;

   bus_responder #(
      .RAM_AW     (11),
      .INIT_FILE  (""),
      .FIFO_DEPTH (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .RW       (RW),
      .AD       (AD),
      .D_in     (D_in),
      .D_out    (D_out),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) m_tick <= 16'h0000;
      else     m_tick <= m_tick + 16'd1;
   end

   task automatic bus_idle();
      RW   = 1'b1;
      AD   = 16'h4000;
      D_in = 8'h00;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      RW   = 1'b0;
      AD   = a;
      D_in = d;
      @(posedge clk);
      #1;
      bus_idle();
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
      RW = 1'b1;
      AD = a;
      @(posedge clk);
      #1;
      d = D_out;
      bus_idle();
   endtask

   task automatic test_reset();
      logic [7:0] rd;
      rst      = 1'b1;
      tx_ready = 1'b0;
      bus_idle();
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (D_out !== 8'h00) begin tests_failed++; $display("FAIL reset_d_out: got %02h expected 00", D_out); end
      tests_run++;
      if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid: got %0b expected 0", tx_valid); end
      tests_run++;
      if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data: got %02h expected 00", tx_data); end
      rst = 1'b0;
      bus_read(16'h8002, rd);
      tests_run++;
      if (rd !== 8'h00) begin tests_failed++; $display("FAIL tick_first: got %02h expected 00", rd); end
      bus_read(16'h8002, rd);
      tests_run++;
      if (rd !== 8'h01) begin tests_failed++; $display("FAIL tick_second: got %02h expected 01", rd); end
      bus_read(16'h8001, rd);
      tests_run++;
      if (rd !== 8'h02) begin tests_failed++; $display("FAIL status_after_reset: got %02h expected 02", rd); end
   endtask

   task automatic test_ram();
      logic [7:0] rd;
      bus_write(16'h0123, 8'h5A);
      bus_read(16'h0123, rd);
      tests_run++;
      if (rd !== 8'h5A) begin tests_failed++; $display("FAIL ram_rw: got %02h expected 5a", rd); end
      bus_write(16'h0200, 8'h77);
      tests_run++;
      if (D_out !== 8'h5A) begin tests_failed++; $display("FAIL d_out_hold_on_write: got %02h expected 5a", D_out); end
      bus_write(16'h07FF, 8'hA5);
      bus_read(16'h07FF, rd);
      tests_run++;
      if (rd !== 8'hA5) begin tests_failed++; $display("FAIL ram_top_byte: got %02h expected a5", rd); end
      bus_read(16'h0800, rd);
      tests_run++;
      if (rd !== 8'hFF) begin tests_failed++; $display("FAIL unmapped_0800: got %02h expected ff", rd); end
      bus_read(16'h0000, rd);
      tests_run++;
      if (rd === 8'hA5) begin tests_failed++; $display("FAIL ram_no_mirror: got %02h expected not a5", rd); end
      bus_read(16'h8000, rd);
      tests_run++;
      if (rd !== 8'h00) begin tests_failed++; $display("FAIL txdata_read: got %02h expected 00", rd); end
      bus_read(16'hFFFF, rd);
      tests_run++;
      if (rd !== 8'hFF) begin tests_failed++; $display("FAIL unmapped_ffff: got %02h expected ff", rd); end
   endtask

   task automatic test_overflow();
      logic [7:0] rd;
      logic [7:0] exp_a [4];
      exp_a = '{8'h11, 8'h22, 8'h33, 8'h44};
      tx_ready = 1'b0;
      bus_write(16'h8000, 8'h11);
      tests_run++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
         tests_failed++; $display("FAIL first_push: got valid=%0b data=%02h expected valid=1 data=11", tx_valid, tx_data);
      end
      bus_write(16'h8000, 8'h22);
      bus_write(16'h8000, 8'h33);
      bus_write(16'h8000, 8'h44);
      bus_write(16'h8000, 8'h55);
      tests_run++;
      if (tx_data !== 8'h11) begin tests_failed++; $display("FAIL head_stable: got %02h expected 11", tx_data); end
      bus_read(16'h8001, rd);
      tests_run++;
      if (rd !== 8'h91) begin tests_failed++; $display("FAIL status_full_ovf: got %02h expected 91", rd); end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (tx_valid !== 1'b1 || tx_data !== exp_a[i]) begin
            tests_failed++; $display("FAIL drain_%0d: got valid=%0b data=%02h expected valid=1 data=%02h", i, tx_valid, tx_data, exp_a[i]);
         end
         @(posedge clk);
         #1;
      end
      tests_run++;
      if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL drained_valid: got %0b expected 0", tx_valid); end
      tx_ready = 1'b0;
      bus_read(16'h8001, rd);
      tests_run++;
      if (rd !== 8'h82) begin tests_failed++; $display("FAIL status_empty_ovf: got %02h expected 82", rd); end
      bus_write(16'h8001, 8'h00);
      bus_read(16'h8001, rd);
      tests_run++;
      if (rd !== 8'h02) begin tests_failed++; $display("FAIL status_ovf_clear: got %02h expected 02", rd); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rd;
      logic [7:0] exp_a [4];
      exp_a = '{8'h02, 8'h03, 8'h04, 8'h66};
      tx_ready = 1'b0;
      bus_write(16'h8000, 8'h01);
      bus_write(16'h8000, 8'h02);
      bus_write(16'h8000, 8'h03);
      bus_write(16'h8000, 8'h04);
      RW       = 1'b0;
      AD       = 16'h8000;
      D_in     = 8'h66;
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      bus_idle();
      tests_run++;
      if (tx_data !== 8'h02) begin tests_failed++; $display("FAIL push_pop_head: got %02h expected 02", tx_data); end
      bus_read(16'h8001, rd);
      tests_run++;
      if (rd !== 8'h11) begin tests_failed++; $display("FAIL push_pop_status: got %02h expected 11", rd); end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (tx_valid !== 1'b1 || tx_data !== exp_a[i]) begin
            tests_failed++; $display("FAIL pp_drain_%0d: got valid=%0b data=%02h expected valid=1 data=%02h", i, tx_valid, tx_data, exp_a[i]);
         end
         @(posedge clk);
         #1;
      end
      tests_run++;
      if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL pp_drained_valid: got %0b expected 0", tx_valid); end
      tx_ready = 1'b0;
   endtask

   task automatic test_tick();
      logic [7:0] rd;
      int n;
      n = 0;
      while (m_tick !== 16'h12FF && n < 70000) begin
         @(posedge clk);
         #1;
         n++;
      end
      tests_run++;
      if (m_tick !== 16'h12FF) begin tests_failed++; $display("FAIL tick_wait: got %04h expected 12ff", m_tick); end
      bus_read(16'h8002, rd);
      tests_run++;
      if (rd !== 8'hFF) begin tests_failed++; $display("FAIL tick_lo: got %02h expected ff", rd); end
      bus_read(16'h8003, rd);
      tests_run++;
      if (rd !== 8'h12) begin tests_failed++; $display("FAIL tick_hi_atomic: got %02h expected 12", rd); end
      bus_write(16'h8003, 8'hEE);
      bus_read(16'h8003, rd);
      tests_run++;
      if (rd !== 8'h12) begin tests_failed++; $display("FAIL tick_hi_hold: got %02h expected 12", rd); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] rd;
      tx_ready = 1'b0;
      bus_write(16'h8000, 8'hA1);
      bus_write(16'h8000, 8'hA2);
      bus_write(16'h8000, 8'hA3);
      RW = 1'b1;
      AD = 16'h0123;
      @(posedge clk);
      #1;
      tests_run++;
      if (D_out !== 8'h5A || tx_valid !== 1'b1) begin
         tests_failed++; $display("FAIL pre_reset: got d_out=%02h valid=%0b expected d_out=5a valid=1", D_out, tx_valid);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL async_tx_valid: got %0b expected 0", tx_valid); end
      tests_run++;
      if (D_out !== 8'h00) begin tests_failed++; $display("FAIL async_d_out: got %02h expected 00", D_out); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus_idle();
      bus_read(16'h8002, rd);
      tests_run++;
      if (rd !== 8'h00) begin tests_failed++; $display("FAIL tick_restart: got %02h expected 00", rd); end
      bus_read(16'h8001, rd);
      tests_run++;
      if (rd !== 8'h02) begin tests_failed++; $display("FAIL status_post_reset: got %02h expected 02", rd); end
      bus_read(16'h0123, rd);
      tests_run++;
      if (rd !== 8'h5A) begin tests_failed++; $display("FAIL ram_kept: got %02h expected 5a", rd); end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_overflow();
      test_back_to_back();
      test_tick();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
